// File: rtl/morse_rx_arbiter.sv
// -----------------------------------------------------------------------------
// MorseRxArbiter (module morse_rx_arbiter)
//
// Purpose:
//   Merges the character strobes of N_CH symbol receivers into one
//   valid/ready stream for a single Morse decoder.
//   - Each channel owns one holding slot that captures a strobed character.
//   - A round-robin arbiter moves the winning slot into the output register.
//   - A strobe that hits a slot that is still occupied is dropped.
//   - Every dropped strobe raises a sticky per-channel overflow flag.
//   Character data passes through unmodified, including the space symbol
//   at full size.
//
// Optional feature (macro MORSE_RX_ARB_OVF_CNT_EN):
//   When this macro is defined, each channel also gets a saturating drop
//   counter of OVF_W bits. When it is undefined, ovf_cnt_o is tied to zero
//   and no counter flops are built.
//
// Ports:
//   clk          : single clock; all state changes on its rising edge
//   reset        : asynchronous, active-high reset
//   s_tvalid_i   : [N_CH]        one-cycle character strobe per channel
//   s_tdata_i    : [N_CH*CW]     symbol buffer per channel (slice k = channel k)
//   s_tsize_i    : [N_CH*SW]     symbol count per channel
//   m_tvalid_o   : output character is valid
//   m_tready_i   : decoder accepts the presented character
//   m_tdata_o    : [CW]          granted character data
//   m_tsize_o    : [SW]          granted character size
//   m_tid_o      : [$clog2(N_CH)] source channel of the presented character
//   ovf_o        : [N_CH]        sticky drop flag per channel
//   ovf_cnt_o    : [N_CH*OVF_W]  drop counter per channel
//
//   CW = MORSE_CHAR_WIDTH_MAX_C, SW = MORSE_SIZE_WIDTH_MAX_C
// -----------------------------------------------------------------------------
module morse_rx_arbiter #(
    parameter  int N_CH                   = 2,
    parameter  int OVF_W                  = 8,
    localparam int MORSE_CHAR_WIDTH_MAX_C = 5,
    localparam int MORSE_SIZE_WIDTH_MAX_C = 3,
    localparam int PTR_W                  = $clog2(N_CH)
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [N_CH-1:0]                        s_tvalid_i,
    input  logic [N_CH*MORSE_CHAR_WIDTH_MAX_C-1:0] s_tdata_i,
    input  logic [N_CH*MORSE_SIZE_WIDTH_MAX_C-1:0] s_tsize_i,
    output logic                                   m_tvalid_o,
    input  logic                                   m_tready_i,
    output logic [MORSE_CHAR_WIDTH_MAX_C-1:0]      m_tdata_o,
    output logic [MORSE_SIZE_WIDTH_MAX_C-1:0]      m_tsize_o,
    output logic [PTR_W-1:0]                       m_tid_o,
    output logic [N_CH-1:0]                        ovf_o,
    output logic [N_CH*OVF_W-1:0]                  ovf_cnt_o
);

    localparam int CW = MORSE_CHAR_WIDTH_MAX_C;
    localparam int SW = MORSE_SIZE_WIDTH_MAX_C;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1
    } state_t;

    state_t            r_state;
    state_t            w_stateNext;

    logic [N_CH-1:0]   r_slotValid;
    logic [CW-1:0]     r_slotData [N_CH];
    logic [SW-1:0]     r_slotSize [N_CH];

    logic [PTR_W-1:0]  r_rrPtr;
    logic [CW-1:0]     r_mData;
    logic [SW-1:0]     r_mSize;
    logic [PTR_W-1:0]  r_mId;
    logic [N_CH-1:0]   r_ovf;

    logic              w_anyFull;
    logic              w_found;
    logic [PTR_W-1:0]  w_grant;
    logic              w_grantEn;
    logic [N_CH-1:0]   w_release;
    logic [N_CH-1:0]   w_drop;

    // Round-robin search: the first full slot at or above rr_ptr, wrapping modulo N_CH.
    always_comb begin
        w_anyFull = |r_slotValid;
        w_found   = 1'b0;
        w_grant   = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (!w_found && r_slotValid[(int'(r_rrPtr) + i) % N_CH]) begin
                w_found = 1'b1;
                w_grant = PTR_W'((int'(r_rrPtr) + i) % N_CH);
            end
        end
    end

    // A grant happens when the output register is empty, or when it is being emptied this cycle.
    // Encodings other than IDLE and HOLD send the FSM back to IDLE.
    always_comb begin
        w_stateNext = r_state;
        w_grantEn   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_anyFull) begin
                    w_grantEn   = 1'b1;
                    w_stateNext = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (m_tready_i) begin
                    if (w_anyFull) begin
                        w_grantEn = 1'b1;
                    end else begin
                        w_stateNext = ST_IDLE;
                    end
                end
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    // A slot that is released this cycle may accept a new strobe, so only
    // a strobe into a full slot that is not being released counts as a drop.
    always_comb begin
        w_release = '0;
        w_drop    = '0;
        for (int k = 0; k < N_CH; k++) begin
            w_release[k] = w_grantEn && (w_grant == PTR_W'(k));
            w_drop[k]    = s_tvalid_i[k] && r_slotValid[k] && !w_release[k];
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Holding slots: load on a strobe into an empty (or just-released) slot, clear on release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_slotValid <= '0;
            for (int k = 0; k < N_CH; k++) begin
                r_slotData[k] <= '0;
                r_slotSize[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                if (s_tvalid_i[k] && (!r_slotValid[k] || w_release[k])) begin
                    r_slotValid[k] <= 1'b1;
                    r_slotData[k]  <= s_tdata_i[k*CW +: CW];
                    r_slotSize[k]  <= s_tsize_i[k*SW +: SW];
                end else if (w_release[k]) begin
                    r_slotValid[k] <= 1'b0;
                end
            end
        end
    end

    // Output register and round-robin pointer.
    // Both change only on a grant, so the presented character stays stable while the decoder stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mData <= '0;
            r_mSize <= '0;
            r_mId   <= '0;
            r_rrPtr <= '0;
        end else if (w_grantEn) begin
            r_mData <= r_slotData[w_grant];
            r_mSize <= r_slotSize[w_grant];
            r_mId   <= w_grant;
            r_rrPtr <= (w_grant == PTR_W'(N_CH - 1)) ? '0 : w_grant + 1'b1;
        end
    end

    // Sticky overflow flags, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ovf <= '0;
        end else begin
            r_ovf <= r_ovf | w_drop;
        end
    end

`ifdef MORSE_RX_ARB_OVF_CNT_EN
    logic [OVF_W-1:0] r_ovfCnt [N_CH];

    // Saturating drop counters: an all-ones counter stays at all-ones instead of wrapping to zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < N_CH; k++) begin
                r_ovfCnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                if (w_drop[k] && (r_ovfCnt[k] != '1)) begin
                    r_ovfCnt[k] <= r_ovfCnt[k] + 1'b1;
                end
            end
        end
    end

    // Pack the counters into the flat output bus.
    always_comb begin
        ovf_cnt_o = '0;
        for (int k = 0; k < N_CH; k++) begin
            ovf_cnt_o[k*OVF_W +: OVF_W] = r_ovfCnt[k];
        end
    end
`else
    assign ovf_cnt_o = '0;
`endif

    assign m_tvalid_o = (r_state == ST_HOLD);
    assign m_tdata_o  = r_mData;
    assign m_tsize_o  = r_mSize;
    assign m_tid_o    = r_mId;
    assign ovf_o      = r_ovf;

endmodule

// File: tb/tb_morse_rx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_morse_rx_arbiter
//
// Purpose:
//   Self-checking bench for morse_rx_arbiter.
//   - Directed scenarios are checked against constants.
//   - A random-traffic run is checked against a behavioural model of the
//     arbiter: slots, output register and round-robin pointer, stepped
//     once per clock.
//   The bench honours the macro MORSE_RX_ARB_OVF_CNT_EN for the
//   expected drop-counter values.
// -----------------------------------------------------------------------------
module tb_morse_rx_arbiter;

    localparam int N_CH  = 2;
    localparam int OVF_W = 8;
    localparam int CW    = 5;
    localparam int SW    = 3;
    localparam int PW    = $clog2(N_CH);
    localparam int CNT_MAX = (1 << OVF_W) - 1;
    localparam logic [CW-1:0] MORSE_SPACE_C = 5'b11111;
`ifdef MORSE_RX_ARB_OVF_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [N_CH-1:0]       s_tvalid_i = '0;
    logic [N_CH*CW-1:0]    s_tdata_i = '0;
    logic [N_CH*SW-1:0]    s_tsize_i = '0;
    logic                  m_tvalid_o;
    logic                  m_tready_i = 1'b1;
    logic [CW-1:0]         m_tdata_o;
    logic [SW-1:0]         m_tsize_o;
    logic [PW-1:0]         m_tid_o;
    logic [N_CH-1:0]       ovf_o;
    logic [N_CH*OVF_W-1:0] ovf_cnt_o;

    int nChecks = 0;
    int nFails  = 0;

    // Behavioural model state.
    bit            mdlValid;
    logic [CW-1:0] mdlData;
    logic [SW-1:0] mdlSize;
    logic [PW-1:0] mdlId;
    bit            mdlSlotV [N_CH];
    logic [CW-1:0] mdlSlotD [N_CH];
    logic [SW-1:0] mdlSlotS [N_CH];
    int            mdlPtr;
    logic [N_CH-1:0] mdlOvf;
    int            mdlCnt [N_CH];

    morse_rx_arbiter #(.N_CH(N_CH), .OVF_W(OVF_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .s_tvalid_i (s_tvalid_i),
        .s_tdata_i  (s_tdata_i),
        .s_tsize_i  (s_tsize_i),
        .m_tvalid_o (m_tvalid_o),
        .m_tready_i (m_tready_i),
        .m_tdata_o  (m_tdata_o),
        .m_tsize_o  (m_tsize_o),
        .m_tid_o    (m_tid_o),
        .ovf_o      (ovf_o),
        .ovf_cnt_o  (ovf_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic modelReset();
        mdlValid = 1'b0;
        mdlData  = '0;
        mdlSize  = '0;
        mdlId    = '0;
        mdlPtr   = 0;
        mdlOvf   = '0;
        for (int k = 0; k < N_CH; k++) begin
            mdlSlotV[k] = 1'b0;
            mdlSlotD[k] = '0;
            mdlSlotS[k] = '0;
            mdlCnt[k]   = 0;
        end
    endtask

    // One clock of the model, using the inputs that the coming edge will sample.
    task automatic modelStep();
        int g = -1;
        if (!mdlValid || m_tready_i) begin
            for (int i = 0; i < N_CH; i++) begin
                if (g < 0 && mdlSlotV[(mdlPtr + i) % N_CH]) g = (mdlPtr + i) % N_CH;
            end
            if (g >= 0) begin
                mdlValid    = 1'b1;
                mdlData     = mdlSlotD[g];
                mdlSize     = mdlSlotS[g];
                mdlId       = PW'(g);
                mdlPtr      = (g + 1) % N_CH;
                mdlSlotV[g] = 1'b0;
            end else begin
                mdlValid = 1'b0;
            end
        end
        for (int k = 0; k < N_CH; k++) begin
            if (s_tvalid_i[k]) begin
                if (!mdlSlotV[k]) begin
                    mdlSlotV[k] = 1'b1;
                    mdlSlotD[k] = s_tdata_i[k*CW +: CW];
                    mdlSlotS[k] = s_tsize_i[k*SW +: SW];
                end else begin
                    mdlOvf[k] = 1'b1;
                    if (CNT_EN && mdlCnt[k] < CNT_MAX) mdlCnt[k]++;
                end
            end
        end
    endtask

    // Advance one clock and settle 1 time unit past the edge.
    task automatic tick();
        if (reset) modelReset();
        else modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int ch, input logic [CW-1:0] d, input logic [SW-1:0] s);
        s_tvalid_i[ch] = 1'b1;
        s_tdata_i[ch*CW +: CW] = d;
        s_tsize_i[ch*SW +: SW] = s;
    endtask

    task automatic clearStrobes();
        s_tvalid_i = '0;
    endtask

    task automatic doReset();
        reset = 1'b1;
        modelReset();
        clearStrobes();
        @(posedge clk);
        #3;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        nChecks++;
        if (m_tvalid_o !== 1'b0) begin nFails++; $display("[TB] FAIL reset_valid got %b want 0", m_tvalid_o); end
        nChecks++;
        if (m_tdata_o !== '0 || m_tsize_o !== '0 || m_tid_o !== '0) begin
            nFails++; $display("[TB] FAIL reset_data got %h/%h/%h want 0/0/0", m_tdata_o, m_tsize_o, m_tid_o);
        end
        nChecks++;
        if (ovf_o !== '0 || ovf_cnt_o !== '0) begin
            nFails++; $display("[TB] FAIL reset_ovf got %b/%h want 0/0", ovf_o, ovf_cnt_o);
        end
        doReset();
    endtask

    task automatic test_single();
        doReset();
        m_tready_i = 1'b1;
        applyStimulus(0, 5'b00010, 3'd3);
        tick();
        clearStrobes();
        nChecks++;
        if (m_tvalid_o !== 1'b0) begin nFails++; $display("[TB] FAIL single_early got %b want 0", m_tvalid_o); end
        tick();
        nChecks++;
        if (m_tvalid_o !== 1'b1 || m_tdata_o !== 5'b00010 || m_tsize_o !== 3'd3 || m_tid_o !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL single_out got v=%b d=%b s=%0d id=%0d want v=1 d=00010 s=3 id=0", m_tvalid_o, m_tdata_o, m_tsize_o, m_tid_o);
        end
        tick();
        nChecks++;
        if (m_tvalid_o !== 1'b0) begin nFails++; $display("[TB] FAIL single_oneCycle got %b want 0", m_tvalid_o); end
    endtask

    task automatic test_round_robin();
        doReset();
        m_tready_i = 1'b1;
        applyStimulus(0, 5'd7, 3'd2);
        applyStimulus(1, 5'd9, 3'd4);
        tick();
        clearStrobes();
        tick();
        nChecks++;
        if (m_tvalid_o !== 1'b1 || m_tid_o !== 1'b0 || m_tdata_o !== 5'd7) begin
            nFails++; $display("[TB] FAIL rr_first got v=%b id=%0d d=%0d want v=1 id=0 d=7", m_tvalid_o, m_tid_o, m_tdata_o);
        end
        tick();
        nChecks++;
        if (m_tvalid_o !== 1'b1 || m_tid_o !== 1'b1 || m_tdata_o !== 5'd9 || m_tsize_o !== 3'd4) begin
            nFails++; $display("[TB] FAIL rr_second got v=%b id=%0d d=%0d s=%0d want v=1 id=1 d=9 s=4", m_tvalid_o, m_tid_o, m_tdata_o, m_tsize_o);
        end
        tick();
        nChecks++;
        if (m_tvalid_o !== 1'b0) begin nFails++; $display("[TB] FAIL rr_idle got %b want 0", m_tvalid_o); end
        // The pointer is back at 0, so a simultaneous pair grants channel 0 first again.
        applyStimulus(0, 5'd1, 3'd1);
        applyStimulus(1, 5'd2, 3'd1);
        tick();
        clearStrobes();
        tick();
        nChecks++;
        if (m_tid_o !== 1'b0 || m_tdata_o !== 5'd1) begin
            nFails++; $display("[TB] FAIL rr_ptrWrap got id=%0d d=%0d want id=0 d=1", m_tid_o, m_tdata_o);
        end
        tick();
        tick();
    endtask

    task automatic test_overflow();
        doReset();
        m_tready_i = 1'b0;
        applyStimulus(1, 5'd3, 3'd2);
        tick();
        applyStimulus(1, 5'd4, 3'd3);
        tick();
        applyStimulus(1, 5'd5, 3'd4);
        tick();
        clearStrobes();
        nChecks++;
        if (m_tvalid_o !== 1'b1 || m_tid_o !== 1'b1 || m_tdata_o !== 5'd3) begin
            nFails++; $display("[TB] FAIL ovf_held got v=%b id=%0d d=%0d want v=1 id=1 d=3", m_tvalid_o, m_tid_o, m_tdata_o);
        end
        nChecks++;
        if (ovf_o !== 2'b10) begin nFails++; $display("[TB] FAIL ovf_flag got %b want 10", ovf_o); end
        nChecks++;
        if (ovf_cnt_o[15:8] !== (CNT_EN ? 8'd1 : 8'd0) || ovf_cnt_o[7:0] !== 8'd0) begin
            nFails++; $display("[TB] FAIL ovf_cnt got %h want %h", ovf_cnt_o, CNT_EN ? 16'h0100 : 16'h0000);
        end
        m_tready_i = 1'b1;
        tick();
        nChecks++;
        if (m_tvalid_o !== 1'b1 || m_tdata_o !== 5'd4 || m_tsize_o !== 3'd3) begin
            nFails++; $display("[TB] FAIL ovf_stored got v=%b d=%0d s=%0d want v=1 d=4 s=3", m_tvalid_o, m_tdata_o, m_tsize_o);
        end
        tick();
        nChecks++;
        if (m_tvalid_o !== 1'b0) begin nFails++; $display("[TB] FAIL ovf_drained got %b want 0", m_tvalid_o); end
    endtask

    task automatic test_hold_stable();
        doReset();
        m_tready_i = 1'b0;
        applyStimulus(0, 5'b10110, 3'd5);
        tick();
        clearStrobes();
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            nChecks++;
            if (m_tvalid_o !== 1'b1 || m_tdata_o !== 5'b10110 || m_tid_o !== 1'b0) begin
                nFails++; $display("[TB] FAIL hold_stable[%0d] got v=%b d=%b id=%0d want v=1 d=10110 id=0", i, m_tvalid_o, m_tdata_o, m_tid_o);
            end
        end
        m_tready_i = 1'b1;
        tick();
        nChecks++;
        if (m_tvalid_o !== 1'b0) begin nFails++; $display("[TB] FAIL hold_single got %b want 0", m_tvalid_o); end
    endtask

    task automatic test_reset_mid_hold();
        doReset();
        m_tready_i = 1'b0;
        applyStimulus(0, 5'd11, 3'd2);
        applyStimulus(1, 5'd12, 3'd2);
        tick();
        clearStrobes();
        applyStimulus(0, 5'd13, 3'd2);
        tick();
        clearStrobes();
        #2;
        reset = 1'b1;
        modelReset();
        #1;
        nChecks++;
        if (m_tvalid_o !== 1'b0 || m_tdata_o !== '0 || m_tsize_o !== '0 || m_tid_o !== '0 || ovf_o !== '0) begin
            nFails++; $display("[TB] FAIL midReset_async got v=%b d=%h s=%h id=%0d ovf=%b want all 0", m_tvalid_o, m_tdata_o, m_tsize_o, m_tid_o, ovf_o);
        end
        applyStimulus(0, 5'd14, 3'd1);
        applyStimulus(1, 5'd15, 3'd1);
        tick();
        clearStrobes();
        #1;
        reset = 1'b0;
        m_tready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            nChecks++;
            if (m_tvalid_o !== 1'b0) begin nFails++; $display("[TB] FAIL midReset_quiet[%0d] got %b want 0", i, m_tvalid_o); end
        end
        applyStimulus(1, 5'd6, 3'd3);
        tick();
        clearStrobes();
        tick();
        nChecks++;
        if (m_tvalid_o !== 1'b1 || m_tid_o !== 1'b1 || m_tdata_o !== 5'd6) begin
            nFails++; $display("[TB] FAIL midReset_resume got v=%b id=%0d d=%0d want v=1 id=1 d=6", m_tvalid_o, m_tid_o, m_tdata_o);
        end
    endtask

    task automatic test_saturation();
        doReset();
        m_tready_i = 1'b0;
        // The first two strobes fill the output register and the slot; the rest are drops.
        for (int i = 0; i < 302; i++) begin
            applyStimulus(0, 5'($urandom), 3'd1);
            tick();
        end
        clearStrobes();
        nChecks++;
        if (ovf_cnt_o[7:0] !== (CNT_EN ? 8'd255 : 8'd0)) begin
            nFails++; $display("[TB] FAIL sat_cnt got %0d want %0d", ovf_cnt_o[7:0], CNT_EN ? 255 : 0);
        end
        nChecks++;
        if (ovf_o !== 2'b01 || ovf_cnt_o[15:8] !== 8'd0) begin
            nFails++; $display("[TB] FAIL sat_flags got ovf=%b cnt1=%0d want ovf=01 cnt1=0", ovf_o, ovf_cnt_o[15:8]);
        end
    endtask

    task automatic test_random();
        doReset();
        for (int c = 0; c < 500; c++) begin
            clearStrobes();
            for (int k = 0; k < N_CH; k++) begin
                if ($urandom_range(99) < 35) begin
                    if ($urandom_range(7) == 0) applyStimulus(k, MORSE_SPACE_C, 3'd5);
                    else applyStimulus(k, 5'($urandom), 3'($urandom_range(5)));
                end
            end
            m_tready_i = ($urandom_range(99) < 60);
            tick();
            nChecks++;
            if (m_tvalid_o !== mdlValid) begin
                nFails++; $display("[TB] FAIL rand_valid[%0d] got %b want %b", c, m_tvalid_o, mdlValid);
            end
            if (mdlValid) begin
                nChecks++;
                if (m_tdata_o !== mdlData || m_tsize_o !== mdlSize || m_tid_o !== mdlId) begin
                    nFails++; $display("[TB] FAIL rand_data[%0d] got d=%h s=%0d id=%0d want d=%h s=%0d id=%0d", c, m_tdata_o, m_tsize_o, m_tid_o, mdlData, mdlSize, mdlId);
                end
            end
            nChecks++;
            if (ovf_o !== mdlOvf || ovf_cnt_o[7:0] !== 8'(mdlCnt[0]) || ovf_cnt_o[15:8] !== 8'(mdlCnt[1])) begin
                nFails++; $display("[TB] FAIL rand_ovf[%0d] got %b/%h want %b/%0d,%0d", c, ovf_o, ovf_cnt_o, mdlOvf, mdlCnt[1], mdlCnt[0]);
            end
        end
        clearStrobes();
    endtask

    initial begin
        modelReset();
        test_reset();
        test_single();
        test_round_robin();
        test_overflow();
        test_hold_stable();
        test_reset_mid_hold();
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
